// File: rtl/phoenix_input_buffer.sv
// Phoenix router input port: credit-controlled flit FIFO that requests a
// route for each packet header and streams the packet once granted.
module phoenix_input_buffer #(
    parameter int TAM_FLIT     = 16,
    parameter int BUFFER_DEPTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic                data_av,
    output logic [TAM_FLIT-1:0] data,
    input  logic                data_ack,
    output logic                sender
);

    localparam int AW = $clog2(BUFFER_DEPTH);
    localparam int CW = $clog2(BUFFER_DEPTH + 1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_HEADER = 2'd1,
        S_SEND   = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              state;
    logic [TAM_FLIT-1:0] mem [BUFFER_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [TAM_FLIT-1:0] remaining;
    logic                hdr_seen;
    logic                size_seen;
    logic                wr;
    logic                rd;

    assign credit_o = reset && (count < CW'(BUFFER_DEPTH));
    assign wr       = rx && credit_o;
    assign data_av  = (state == S_SEND) && (count != '0);
    assign rd       = data_av && data_ack;
    assign data     = mem[rd_ptr];

    // Storage is not reset; stale contents are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_INIT;
            h         <= 1'b0;
            sender    <= 1'b0;
            remaining <= '0;
            hdr_seen  <= 1'b0;
            size_seen <= 1'b0;
        end else begin
            unique case (state)
                S_INIT: begin
                    h      <= 1'b0;
                    sender <= 1'b0;
                    if (count != '0) begin
                        state <= S_HEADER;
                        h     <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (ack_h) begin
                        state  <= S_SEND;
                        h      <= 1'b0;
                        sender <= 1'b1;
                    end
                end
                S_SEND: begin
                    if (rd) begin
                        if (!hdr_seen) begin
                            hdr_seen <= 1'b1;
                        end else if (!size_seen) begin
                            remaining <= data;
                            size_seen <= 1'b1;
                            if (data == '0) begin
                                state  <= S_END;
                                sender <= 1'b0;
                            end
                        end else begin
                            remaining <= remaining - 1'b1;
                            if (remaining == TAM_FLIT'(1)) begin
                                state  <= S_END;
                                sender <= 1'b0;
                            end
                        end
                    end
                end
                S_END: begin
                    state     <= S_INIT;
                    h         <= 1'b0;
                    sender    <= 1'b0;
                    hdr_seen  <= 1'b0;
                    size_seen <= 1'b0;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
